// File: rtl/ddc_nco_decim.sv
// ddc_nco_decim
// Digital down-converter. A real IF sample stream is mixed with a
// table-based NCO to complex baseband. The mixed terms are summed over
// windows of 2^D accepted samples (integrate-and-dump). Each window sum is
// rounded, scaled down by 2^D and saturated before it reaches a ready/valid
// output register.
//
// Pipeline, counted from the edge that accepts a sample:
//   edge 0: phase/sample register
//   edge 1: cos/sin LUT read
//   edge 2: full-precision multiply
//   edge 3: round to WI+1 bits
//   edge 4: accumulate, and on the last sample of a window dump into I_out/Q_out
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   adc_in        signed WI-bit IF sample, accepted when adc_val is high
//   fcw           NCO frequency control word, captured when fcw_load pulses
//   phase_clr     zeroes the NCO phase and flushes the partial window and pipeline
//   decim_log2    decimation exponent D, clamped to DLOG_MAX, taken at window start
//   I_out, Q_out  signed WO-bit baseband result
//   iq_out_val    a result is held; it is consumed when iq_out_rdy is also high
//   iq_out_rdy    consumer accept
//   ovf           sticky: an unconsumed result was overwritten
//   sat           sticky: an I or Q result was clipped to WO bits
module ddc_nco_decim #(
    parameter int WI       = 16,
    parameter int WO       = 16,
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 10,
    parameter int COEF_W   = 16,
    parameter int DLOG_MAX = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [WI-1:0]             adc_in,
    input  logic                             adc_val,
    input  logic [PHASE_W-1:0]               fcw,
    input  logic                             fcw_load,
    input  logic                             phase_clr,
    input  logic [$clog2(DLOG_MAX+1)-1:0]    decim_log2,
    output logic signed [WO-1:0]             I_out,
    output logic signed [WO-1:0]             Q_out,
    output logic                             iq_out_val,
    input  logic                             iq_out_rdy,
    output logic                             ovf,
    output logic                             sat
);

    localparam int DW    = $clog2(DLOG_MAX + 1);
    localparam int CW    = DLOG_MAX + 1;
    localparam int LUT_N = 1 << LUT_AW;
    localparam int AMP   = (1 << (COEF_W - 1)) - 1;
    localparam int PW    = WI + COEF_W;
    localparam int TW    = WI + 1;
    localparam int ACC_W = WI + 1 + DLOG_MAX;
    localparam int SW    = ACC_W + 1;

    localparam logic signed [PW-1:0] RND     = PW'(1) << (COEF_W - 2);
    localparam logic signed [SW-1:0] OUT_MAX = SW'((1 << (WO - 1)) - 1);
    localparam logic signed [SW-1:0] OUT_MIN = ~OUT_MAX;

    // Cosine table entry, rounded half away from zero. It is evaluated at
    // elaboration, so the table becomes a constant ROM.
    function automatic logic signed [COEF_W-1:0] cos_entry(input int k);
        real x;
        x = real'(AMP) * $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N));
        if (x >= 0.0)
            return COEF_W'($rtoi(x + 0.5));
        else
            return COEF_W'(-$rtoi(0.5 - x));
    endfunction

    // Drop the COEF_W-1 fraction bits with round-half-up.
    function automatic logic signed [TW-1:0] round_term(input logic signed [PW-1:0] p);
        return TW'((p + RND) >>> (COEF_W - 1));
    endfunction

    // Divide the window sum by 2^d with round-half-up. One extra bit of
    // headroom keeps the rounding add from wrapping.
    function automatic logic signed [SW-1:0] dump_scale(input logic signed [ACC_W-1:0] s,
                                                        input logic [DW-1:0] d);
        logic signed [SW-1:0] half;
        half = (SW'(1) << d) >> 1;
        return (SW'(s) + half) >>> d;
    endfunction

    function automatic logic signed [WO-1:0] saturate(input logic signed [SW-1:0] x);
        if (x > OUT_MAX)
            return WO'(OUT_MAX);
        else if (x < OUT_MIN)
            return WO'(OUT_MIN);
        else
            return WO'(x);
    endfunction

    logic signed [COEF_W-1:0] cos_rom [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        assign cos_rom[k] = cos_entry(k);
    end

    // NCO and window bookkeeping state
    logic [PHASE_W-1:0] phase, fcw_act;
    logic [CW-1:0]      win_cnt;
    logic [DW-1:0]      win_d;

    // Pipeline stages
    logic                     s1_val, s2_val, s3_val, s4_val;
    logic                     s1_last, s2_last, s3_last, s4_last;
    logic [DW-1:0]            s1_d, s2_d, s3_d, s4_d;
    logic signed [WI-1:0]     s1_adc, s2_adc;
    logic [LUT_AW-1:0]        s1_idx;
    logic signed [COEF_W-1:0] s2_cos, s2_sin;
    logic signed [PW-1:0]     s3_i, s3_q;
    logic signed [TW-1:0]     s4_i, s4_q;
    logic signed [ACC_W-1:0]  acc_i, acc_q;

    // Input-side decode. A phase_clr makes this sample the first of a fresh
    // window at phase 0. The window length is fixed when the window opens.
    logic [DW-1:0]      d_clamp, d_eff;
    logic [CW-1:0]      cnt_eff, win_mask;
    logic [PHASE_W-1:0] phase_eff, fcw_inc;
    logic               win_last;

    always_comb begin
        d_clamp   = (decim_log2 > DW'(DLOG_MAX)) ? DW'(DLOG_MAX) : decim_log2;
        cnt_eff   = phase_clr ? '0 : win_cnt;
        d_eff     = (cnt_eff == '0) ? d_clamp : win_d;
        win_mask  = (CW'(1) << d_eff) - CW'(1);
        win_last  = (cnt_eff == win_mask);
        phase_eff = phase_clr ? '0 : phase;
        fcw_inc   = fcw_load ? fcw : fcw_act;
    end

    // NCO phase, window counter and stage 1. A sample uses the phase held
    // before its own increment. An fcw_load in the same cycle changes only
    // the increment that follows that sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= '0;
            fcw_act <= '0;
            win_cnt <= '0;
            win_d   <= '0;
            s1_val  <= 1'b0;
            s1_last <= 1'b0;
            s1_d    <= '0;
            s1_adc  <= '0;
            s1_idx  <= '0;
        end else begin
            if (fcw_load)
                fcw_act <= fcw;
            if (adc_val) begin
                phase   <= phase_eff + fcw_inc;
                win_cnt <= win_last ? '0 : cnt_eff + CW'(1);
                win_d   <= d_eff;
            end else if (phase_clr) begin
                phase   <= '0;
                win_cnt <= '0;
            end
            s1_val  <= adc_val;
            s1_last <= win_last;
            s1_d    <= d_eff;
            s1_adc  <= adc_in;
            s1_idx  <= phase_eff[PHASE_W-1 -: LUT_AW];
        end
    end

    // LUT, multiply and round stages. A phase_clr kills any samples that are
    // still in flight, so a partial window from before the clear never dumps.
    // Sine is cosine delayed by a quarter turn in the same table.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_val <= 1'b0;
            s3_val <= 1'b0;
            s4_val <= 1'b0;
            s2_last <= 1'b0;
            s3_last <= 1'b0;
            s4_last <= 1'b0;
            s2_d   <= '0;
            s3_d   <= '0;
            s4_d   <= '0;
            s2_adc <= '0;
            s2_cos <= '0;
            s2_sin <= '0;
            s3_i   <= '0;
            s3_q   <= '0;
            s4_i   <= '0;
            s4_q   <= '0;
        end else begin
            s2_val  <= s1_val && !phase_clr;
            s3_val  <= s2_val && !phase_clr;
            s4_val  <= s3_val && !phase_clr;
            s2_last <= s1_last;
            s3_last <= s2_last;
            s4_last <= s3_last;
            s2_d    <= s1_d;
            s3_d    <= s2_d;
            s4_d    <= s3_d;
            s2_adc  <= s1_adc;
            s2_cos  <= cos_rom[s1_idx];
            s2_sin  <= cos_rom[s1_idx - LUT_AW'(LUT_N / 4)];
            s3_i    <= PW'(s2_adc) * PW'(s2_cos);
            s3_q    <= -(PW'(s2_adc) * PW'(s2_sin));
            s4_i    <= round_term(s3_i);
            s4_q    <= round_term(s3_q);
        end
    end

    // Window sum and dump value, worked out one stage ahead of the output register
    logic signed [ACC_W-1:0] sum_i, sum_q;
    logic signed [SW-1:0]    dump_i, dump_q;
    logic                    clip, do_dump;

    always_comb begin
        sum_i   = acc_i + ACC_W'(s4_i);
        sum_q   = acc_q + ACC_W'(s4_q);
        dump_i  = dump_scale(sum_i, s4_d);
        dump_q  = dump_scale(sum_q, s4_d);
        clip    = (dump_i > OUT_MAX) || (dump_i < OUT_MIN) ||
                  (dump_q > OUT_MAX) || (dump_q < OUT_MIN);
        do_dump = s4_val && s4_last && !phase_clr;
    end

    // Accumulator and output register. A new dump always wins, and it
    // overwrites a result that has not been consumed. When no dump arrives,
    // a transfer empties the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i      <= '0;
            acc_q      <= '0;
            I_out      <= '0;
            Q_out      <= '0;
            iq_out_val <= 1'b0;
            ovf        <= 1'b0;
            sat        <= 1'b0;
        end else begin
            if (phase_clr) begin
                acc_i <= '0;
                acc_q <= '0;
            end else if (s4_val) begin
                acc_i <= s4_last ? '0 : sum_i;
                acc_q <= s4_last ? '0 : sum_q;
            end
            if (do_dump) begin
                I_out      <= saturate(dump_i);
                Q_out      <= saturate(dump_q);
                iq_out_val <= 1'b1;
                if (iq_out_val && !iq_out_rdy)
                    ovf <= 1'b1;
                if (clip)
                    sat <= 1'b1;
            end else if (iq_out_val && iq_out_rdy) begin
                iq_out_val <= 1'b0;
            end
        end
    end

endmodule
